sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter sharing one `sram_controller` (32-bit, 2-cycle write, 5-cycle read) between two requesters, e.g. instruction fetch (port 0) and LSU (port 1). It latches one request, presents it to the controller for exactly one cycle, and waits for the controller's ACK. It then routes read data and a one-cycle ACK back to the granted requester. A watchdog frees the bus if the controller never acknowledges.

## Interface
- `TIMEOUT_CYC`, default 15: max cycles in WAIT before abort; legal range 8..255.
- `i_clk` in 1: clock.
- `i_reset` in 1: reset, synchronous, active-low.
- `i_REQn_ADDR` in 18, n=0,1: requester word address, passed through unmodified.
- `i_REQn_WDATA` in 32: write data.
- `i_REQn_BMASK` in 4: byte enables.
- `i_REQn_WREN` / `i_REQn_RDEN` in 1: request type; held until this port's ACK.
- `o_REQn_RDATA` out 32: read data, valid only while `o_REQn_ACK`=1.
- `o_REQn_ACK` out 1: one-cycle completion pulse.
- `o_REQn_ERR` out 1: qualifies `o_REQn_ACK`; 1 = timeout abort.
- `o_SC_ADDR` out 18, `o_SC_WDATA` out 32, `o_SC_BMASK` out 4, `o_SC_WREN` out 1, `o_SC_RDEN` out 1: command to the controller.
- `i_SC_RDATA` in 32, `i_SC_ACK` in 1: controller response.
- `o_GNT` out 1: port currently owning the controller; valid in ISSUE and WAIT.

## Operation
- **Valid request:** exactly one of WREN/RDEN is high. Both high or both low means no request, matching the controller.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any port has a valid request, select the winner and latch its addr/wdata/bmask/type into command registers.
  - Set `gnt_q`; go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - Drive `o_SC_*` from the command registers for exactly this one cycle.
  - Clear the watchdog counter; go to WAIT.
- **WAIT:**
  - Drive `o_SC_WREN`=`o_SC_RDEN`=0 and `o_SC_ADDR/WDATA/BMASK`=0, so the controller never re-triggers in its ACK state.
  - Increment the watchdog each cycle.
  - If `i_SC_ACK`=1: assert `o_REQ[gnt]_ACK` combinationally and set `o_REQ[gnt]_RDATA`=`i_SC_RDATA`; go to IDLE.
  - Else if watchdog = `TIMEOUT_CYC`-1: assert `o_REQ[gnt]_ACK` and `o_REQ[gnt]_ERR`, with RDATA=0; go to IDLE.
- **Non-granted port:** ACK, ERR and RDATA are always 0.
- **`i_SC_ACK` outside WAIT:** ignored.
- **Request changes:** changes on the granted port after latching are ignored until ACK. The requester must drop or replace its request on the edge after its ACK. A request still present in IDLE is treated as new.
- **Watchdog:** width `$clog2(TIMEOUT_CYC+1)` bits; saturates, never wraps.
- **Reset:**
  - FSM to IDLE; command registers, watchdog and `gnt_q` to 0.
  - Round-robin pointer `last_q`=1, so port 0 wins first.
  - All outputs are 0 at reset.
  - Reset mid-transfer drops the transfer with no ACK. The controller shares `i_reset`, so both restart in idle.

## Timing
- Request seen in IDLE at cycle 0 → ISSUE at cycle 1 → controller latches at edge 2.
- Write: requester ACK in cycle 3 (latency 3). Read: requester ACK in cycle 6 (latency 6).
- **Back-to-back:** the next request is sampled in the IDLE cycle after an ACK. Minimum spacing between grants is 4 cycles for writes and 7 for reads.
- **Simultaneous valid requests in IDLE:** resolved by the `SRAM_ARB_RR_EN` policy (see Configuration).
- No combinational path from `i_REQn_*` to `o_SC_*`. The `i_SC_ACK`→`o_REQn_ACK` and `i_SC_RDATA`→`o_REQn_RDATA` paths are combinational through the `gnt_q` mux.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - On contention, grant the port ≠ `last_q`.
  - `last_q` updates to the winner on IDLE→ISSUE.
  - A lone requester always wins.
- `SRAM_ARB_RR_EN` undefined: fixed priority; port 0 always wins on contention. `last_q` is not implemented.

## Test plan
- **Single write:** port 0 writes addr 18'h00010, data 32'hDEADBEEF, bmask 4'hF at cycle 0 → `o_SC_WREN`=1 only in cycle 1; `o_REQ0_ACK` in cycle 3; ERR=0.
- **Single read:** port 1 reads addr 18'h00010 with a controller model returning 32'hDEADBEEF → `o_REQ1_ACK` in cycle 6 with RDATA=32'hDEADBEEF; `o_REQ0_ACK`=0 throughout.
- **Contention (RR_EN defined):** both ports read continuously for 4 transactions → grant order 0,1,0,1. With RR_EN undefined, grant order 0,0,0,0 while port 0 holds its request.
- **Illegal request:** WREN=RDEN=1 on port 0 → no ISSUE, `o_SC_*` stays 0, no ACK.
- **Timeout:** stub never asserts `i_SC_ACK` → `o_REQ0_ACK`=`o_REQ0_ERR`=1 exactly 15 cycles after ISSUE; FSM back in IDLE.
- **Reset mid-read:** `i_reset`=0 in cycle 3 of a read → in the next cycle all outputs are 0 and FSM is IDLE; the next request from port 0 wins and completes normally.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester and controller signal bundle for sram_arbiter; names are from the arbiter's side.
// slave = arbiter, master = requesters plus controller (test environment).
interface sram_arbiter_if;
  logic [17:0] i_REQ0_ADDR;
  logic [31:0] i_REQ0_WDATA;
  logic [3:0]  i_REQ0_BMASK;
  logic        i_REQ0_WREN;
  logic        i_REQ0_RDEN;
  logic [31:0] o_REQ0_RDATA;
  logic        o_REQ0_ACK;
  logic        o_REQ0_ERR;

  logic [17:0] i_REQ1_ADDR;
  logic [31:0] i_REQ1_WDATA;
  logic [3:0]  i_REQ1_BMASK;
  logic        i_REQ1_WREN;
  logic        i_REQ1_RDEN;
  logic [31:0] o_REQ1_RDATA;
  logic        o_REQ1_ACK;
  logic        o_REQ1_ERR;

  logic [17:0] o_SC_ADDR;
  logic [31:0] o_SC_WDATA;
  logic [3:0]  o_SC_BMASK;
  logic        o_SC_WREN;
  logic        o_SC_RDEN;
  logic [31:0] i_SC_RDATA;
  logic        i_SC_ACK;

  logic        o_GNT;

  modport slave (
    input  i_REQ0_ADDR, i_REQ0_WDATA, i_REQ0_BMASK, i_REQ0_WREN, i_REQ0_RDEN,
    output o_REQ0_RDATA, o_REQ0_ACK, o_REQ0_ERR,
    input  i_REQ1_ADDR, i_REQ1_WDATA, i_REQ1_BMASK, i_REQ1_WREN, i_REQ1_RDEN,
    output o_REQ1_RDATA, o_REQ1_ACK, o_REQ1_ERR,
    output o_SC_ADDR, o_SC_WDATA, o_SC_BMASK, o_SC_WREN, o_SC_RDEN,
    input  i_SC_RDATA, i_SC_ACK,
    output o_GNT
  );

  modport master (
    output i_REQ0_ADDR, i_REQ0_WDATA, i_REQ0_BMASK, i_REQ0_WREN, i_REQ0_RDEN,
    input  o_REQ0_RDATA, o_REQ0_ACK, o_REQ0_ERR,
    output i_REQ1_ADDR, i_REQ1_WDATA, i_REQ1_BMASK, i_REQ1_WREN, i_REQ1_RDEN,
    input  o_REQ1_RDATA, o_REQ1_ACK, o_REQ1_ERR,
    input  o_SC_ADDR, o_SC_WDATA, o_SC_BMASK, o_SC_WREN, o_SC_RDEN,
    output i_SC_RDATA, i_SC_ACK,
    input  o_GNT
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of one SRAM controller: IDLE -> ISSUE (one-cycle command) -> WAIT (ACK or watchdog).
// Define SRAM_ARB_RR_EN for round-robin on contention; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int TIMEOUT_CYC = 15
) (
  input logic          i_clk,
  input logic          i_reset,
  sram_arbiter_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t         r_state;
  logic [WDW-1:0] r_wd;
  logic           r_gnt;
  logic [17:0]    r_addr;
  logic [31:0]    r_wdata;
  logic [3:0]     r_bmask;
  logic           r_wren;
  logic           r_rden;
`ifdef SRAM_ARB_RR_EN
  logic           r_last;
`endif

  logic w_vld0, w_vld1, w_win, w_wait, w_timeout, w_done;

  // Both or neither enable set is not a request, mirroring the controller.
  assign w_vld0 = bus.i_REQ0_WREN ^ bus.i_REQ0_RDEN;
  assign w_vld1 = bus.i_REQ1_WREN ^ bus.i_REQ1_RDEN;

  always_comb begin
    w_win = 1'b0;
`ifdef SRAM_ARB_RR_EN
    if (w_vld0 && w_vld1) w_win = ~r_last;
    else                  w_win = ~w_vld0;
`else
    w_win = ~w_vld0;
`endif
  end

  assign w_wait    = (r_state == S_WAIT);
  assign w_timeout = (r_wd == WDW'(TIMEOUT_CYC - 1));
  assign w_done    = w_wait && (bus.i_SC_ACK || w_timeout);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
      r_gnt   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bmask <= '0;
      r_wren  <= 1'b0;
      r_rden  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_vld0 || w_vld1) begin
            r_gnt   <= w_win;
            r_addr  <= w_win ? bus.i_REQ1_ADDR  : bus.i_REQ0_ADDR;
            r_wdata <= w_win ? bus.i_REQ1_WDATA : bus.i_REQ0_WDATA;
            r_bmask <= w_win ? bus.i_REQ1_BMASK : bus.i_REQ0_BMASK;
            r_wren  <= w_win ? bus.i_REQ1_WREN  : bus.i_REQ0_WREN;
            r_rden  <= w_win ? bus.i_REQ1_RDEN  : bus.i_REQ0_RDEN;
`ifdef SRAM_ARB_RR_EN
            r_last  <= w_win;
`endif
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Command registers double as o_SC_*, so clearing them idles the bus during WAIT.
          r_addr  <= '0;
          r_wdata <= '0;
          r_bmask <= '0;
          r_wren  <= 1'b0;
          r_rden  <= 1'b0;
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wd != '1) r_wd <= r_wd + 1'b1;
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_SC_ADDR  = r_addr;
  assign bus.o_SC_WDATA = r_wdata;
  assign bus.o_SC_BMASK = r_bmask;
  assign bus.o_SC_WREN  = r_wren;
  assign bus.o_SC_RDEN  = r_rden;
  assign bus.o_GNT      = r_gnt;

  // A real ACK wins over a simultaneous watchdog expiry.
  assign bus.o_REQ0_ACK   = w_done && !r_gnt;
  assign bus.o_REQ1_ACK   = w_done &&  r_gnt;
  assign bus.o_REQ0_ERR   = w_done && !r_gnt && !bus.i_SC_ACK;
  assign bus.o_REQ1_ERR   = w_done &&  r_gnt && !bus.i_SC_ACK;
  assign bus.o_REQ0_RDATA = (w_wait && !r_gnt && bus.i_SC_ACK) ? bus.i_SC_RDATA : 32'h0;
  assign bus.o_REQ1_RDATA = (w_wait &&  r_gnt && bus.i_SC_ACK) ? bus.i_SC_RDATA : 32'h0;
endmodule
